param_univ_shift_reg: RTL and testbench

//   Parametrised universal shift register. WIDTH-bit register with hold, logical

---
 rtl/param_univ_shift_reg_pkg.sv | 21 ++
 rtl/univ_shift_step.sv | 32 +++
 rtl/param_univ_shift_reg.sv | 89 ++++++++
 tb/tb_param_univ_shift_reg.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/param_univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode codes and FSM states.
// Optional feature macro used by this block: USR_ROTATE_EN (rotate modes 100/101).
package param_univ_shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHL  = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_LOAD = 3'b011;
  localparam mode_t MODE_ROTL = 3'b100;
  localparam mode_t MODE_ROTR = 3'b101;
  localparam mode_t MODE_ASHR = 3'b110;
  localparam mode_t MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_step.sv
// Combinational next-value function of the shift register.
// Rotate codes are only built when USR_ROTATE_EN is defined; otherwise they hold.
module univ_shift_step
  import param_univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] nxt
);

  // Select next register value for the requested operation; unknown codes hold.
  always_comb begin
    nxt = q;
    case (mode)
      MODE_SHL:  nxt = {q[WIDTH-2:0], sin_lsb};
      MODE_SHR:  nxt = {sin_msb, q[WIDTH-1:1]};
      MODE_LOAD: nxt = par_in;
`ifdef USR_ROTATE_EN
      MODE_ROTL: nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: nxt = {q[0], q[WIDTH-1:1]};
`endif
      MODE_ASHR: nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   nxt = q;
    endcase
  end

endmodule

// File: rtl/param_univ_shift_reg.sv
// Universal shift register with a burst sequencer: a start pulse runs `count`
// consecutive steps of the latched mode, then pulses done for one cycle.
// Optional rotate modes are enabled with USR_ROTATE_EN.
module param_univ_shift_reg
  import param_univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               CNT_W     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] data_out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  state_t           st;
  logic [CNT_W-1:0] remaining;
  mode_t            mode_lat;
  mode_t            mode_sel;
  logic [WIDTH-1:0] step_q;

  // During a burst the latched mode drives the datapath; live mode otherwise.
  assign mode_sel = (st == ST_BURST) ? mode_lat : mode;

  univ_shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (data_out),
    .mode    (mode_sel),
    .sin_lsb (sin_lsb),
    .sin_msb (sin_msb),
    .par_in  (par_in),
    .nxt     (step_q)
  );

  assign sout_msb = data_out[WIDTH-1];
  assign sout_lsb = data_out[0];

  // Sequencer FSM, step counter and register; done is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_IDLE;
      remaining <= '0;
      mode_lat  <= MODE_HOLD;
      data_out  <= RESET_VAL;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (start) begin
            // start has priority over en; a zero-length burst only pulses done
            if (count != '0) begin
              mode_lat  <= mode;
              remaining <= count;
              busy      <= 1'b1;
              st        <= ST_BURST;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            data_out <= step_q;
          end
        end
        ST_BURST: begin
          data_out  <= step_q;
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
            st   <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_univ_shift_reg.sv
// Directed self-checking bench for param_univ_shift_reg (WIDTH=4, CNT_W=3).
module tb_param_univ_shift_reg;
  import param_univ_shift_reg_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       start;
  logic [2:0] count;
  logic       sin_lsb;
  logic       sin_msb;
  logic [3:0] par_in;
  logic [3:0] data_out;
  logic       sout_msb;
  logic       sout_lsb;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  param_univ_shift_reg #(.WIDTH(4), .CNT_W(3), .RESET_VAL(4'b0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .start    (start),
    .count    (count),
    .sin_lsb  (sin_lsb),
    .sin_msb  (sin_msb),
    .par_in   (par_in),
    .data_out (data_out),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .busy     (busy),
    .done     (done)
  );

  // Posedges at 10, 20, 30 ...; inputs change and outputs are sampled on negedges.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] d, input logic b, input logic dn);
    chk({tag, ".data"}, 32'(data_out), 32'(d));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [3:0] rot1, rot2;

  initial begin
`ifdef USR_ROTATE_EN
    rot1 = 4'b0011; rot2 = 4'b0110;
`else
    rot1 = 4'b1001; rot2 = 4'b1001;
`endif
    // 1. reset held 15 ns with start asserted
    reset = 1'b0; start = 1'b1; en = 1'b0; mode = MODE_HOLD; count = 3'd0;
    sin_lsb = 1'b0; sin_msb = 1'b0; par_in = 4'b0000;
    #1;  chk_all("rst_t1", 4'b0000, 1'b0, 1'b0);
    #11; chk_all("rst_t12", 4'b0000, 1'b0, 1'b0);
    #3;  reset = 1'b1; start = 1'b0;
    tick(); chk_all("rst_rel", 4'b0000, 1'b0, 1'b0);

    // 2. single steps
    en = 1'b1; mode = MODE_LOAD; par_in = 4'b1010;
    tick(); chk_all("load", 4'b1010, 1'b0, 1'b0);
    mode = MODE_SHL; sin_lsb = 1'b1;
    tick(); chk("shl", 32'(data_out), 32'h5);
    chk("sout_msb", 32'(sout_msb), 32'h0);
    chk("sout_lsb", 32'(sout_lsb), 32'h1);
    mode = MODE_SHR; sin_msb = 1'b1;
    tick(); chk("shr", 32'(data_out), 32'hA);
    mode = MODE_ASHR;
    tick(); chk("ashr", 32'(data_out), 32'hD);
    mode = MODE_HOLD;
    tick(); chk("hold", 32'(data_out), 32'hD);
    mode = MODE_RSVD;
    tick(); chk("rsvd", 32'(data_out), 32'hD);

    // 3. burst SHL x3 from 0001, en high throughout the start
    mode = MODE_LOAD; par_in = 4'b0001;
    tick(); chk("pre_burst", 32'(data_out), 32'h1);
    mode = MODE_SHL; sin_lsb = 1'b0; start = 1'b1; count = 3'd3;
    tick(); chk_all("b_acc", 4'b0001, 1'b1, 1'b0);
    start = 1'b0; mode = MODE_LOAD; par_in = 4'b1111;
    tick(); chk_all("b_s1", 4'b0010, 1'b1, 1'b0);
    tick(); chk_all("b_s2", 4'b0100, 1'b1, 1'b0);
    tick(); chk_all("b_s3", 4'b1000, 1'b0, 1'b1);
    en = 1'b0;
    tick(); chk_all("b_post", 4'b1000, 1'b0, 1'b0);

    // 4. zero-length burst with en also high: start wins
    start = 1'b1; count = 3'd0; en = 1'b1; mode = MODE_LOAD; par_in = 4'b0110;
    tick(); chk_all("z_done", 4'b1000, 1'b0, 1'b1);
    start = 1'b0; en = 1'b0;
    tick(); chk_all("z_post", 4'b1000, 1'b0, 1'b0);

    // 5. rotate burst ROTL x2 from 1001
    en = 1'b1; mode = MODE_LOAD; par_in = 4'b1001;
    tick(); chk("pre_rot", 32'(data_out), 32'h9);
    en = 1'b0; start = 1'b1; mode = MODE_ROTL; count = 3'd2;
    tick(); chk_all("r_acc", 4'b1001, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk_all("r_s1", rot1, 1'b1, 1'b0);
    tick(); chk_all("r_s2", rot2, 1'b0, 1'b1);
    tick(); chk_all("r_post", rot2, 1'b0, 1'b0);

    // 6. reset mid-burst: SHR x7 from 1111, abort after 3 steps
    en = 1'b1; mode = MODE_LOAD; par_in = 4'b1111;
    tick(); chk("pre_abort", 32'(data_out), 32'hF);
    en = 1'b0; start = 1'b1; mode = MODE_SHR; count = 3'd7; sin_msb = 1'b0;
    tick(); chk_all("a_acc", 4'b1111, 1'b1, 1'b0);
    start = 1'b0;
    tick(); tick(); tick(); chk_all("a_s3", 4'b0001, 1'b1, 1'b0);
    #2; reset = 1'b0;
    #1; chk_all("a_async", 4'b0000, 1'b0, 1'b0);
    tick(); reset = 1'b1;
    tick(); chk_all("a_after", 4'b0000, 1'b0, 1'b0);
    start = 1'b1; mode = MODE_SHL; count = 3'd1; sin_lsb = 1'b1;
    tick(); chk_all("n_acc", 4'b0000, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk_all("n_s1", 4'b0001, 1'b0, 1'b1);
    tick(); chk_all("n_post", 4'b0001, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
